// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the core load/store port
// and a debug/loader port: round-robin arbitration, store lane steering, load extraction.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    output logic              core_misalign,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {IDLE, RD_WAIT} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;       // 1 = debug port owns the pending read
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        last_dbg_q, last_dbg_d;

    logic        is_half, is_word, misalign, core_ok, grant_core, grant_dbg;
    logic [3:0]  store_be;
    logic [31:0] store_data, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_bits;

    assign unused_bits = ^{core_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    assign is_half  = (core_size == 2'b01);
    assign is_word  = core_size[1];
    assign misalign = core_req && ((is_half && core_addr[0]) ||
                                   (is_word && (core_addr[1:0] != 2'b00)));
    assign core_ok  = core_req && !misalign;

    // On a tie the port that did not win last time is granted.
    assign grant_core = core_ok && (!dbg_req || last_dbg_q);
    assign grant_dbg  = dbg_req && (!core_ok || !last_dbg_q);

    always_comb begin
        store_be   = 4'b1111;
        store_data = core_wdata;
        if (core_size == 2'b00) begin
            store_be   = 4'b0001 << core_addr[1:0];
            store_data = {4{core_wdata[7:0]}};
        end else if (is_half) begin
            store_be   = core_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{core_wdata[15:0]}};
        end
    end

    assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        unique case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        off_d         = off_q;
        size_d        = size_q;
        uns_d         = uns_q;
        last_dbg_d    = last_dbg_q;
        core_rdata    = '0;
        core_stall    = 1'b0;
        core_misalign = 1'b0;
        dbg_rdata     = '0;
        dbg_ack       = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    core_misalign = misalign;
                    if (grant_core) begin
                        mem_en     = 1'b1;
                        mem_we     = core_we;
                        mem_addr   = core_addr[ADDR_W+1:2];
                        last_dbg_d = 1'b0;
                        if (core_we) begin
                            mem_be    = store_be;
                            mem_wdata = store_data;
                        end else begin
                            state_d = RD_WAIT;
                            owner_d = 1'b0;
                            off_d   = core_addr[1:0];
                            size_d  = core_size;
                            uns_d   = core_unsigned;
                        end
                    end else if (grant_dbg) begin
                        mem_en     = 1'b1;
                        mem_we     = dbg_we;
                        mem_addr   = dbg_addr[ADDR_W+1:2];
                        last_dbg_d = 1'b1;
                        if (dbg_we) begin
                            mem_be    = 4'b1111;
                            mem_wdata = dbg_wdata;
                            dbg_ack   = 1'b1;
                            dbg_rdata = mem_rdata;
                        end else begin
                            state_d = RD_WAIT;
                            owner_d = 1'b1;
                        end
                    end
                    core_stall = core_req && !(grant_core && core_we) && !misalign;
                end
                RD_WAIT: begin
                    state_d = IDLE;
                    if (owner_q) begin
                        dbg_ack   = 1'b1;
                        dbg_rdata = mem_rdata;
                    end else begin
                        core_rdata = load_data;
                    end
                    core_stall = core_req && owner_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            last_dbg_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            last_dbg_q <= last_dbg_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a byte-array reference memory
// predicts every core/debug completion, a monitor pops and compares.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_unsigned;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_size;
    logic [31:0] core_rdata;
    logic        core_stall, core_misalign;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk_data;
        bit          mis;
        logic [31:0] rdata;
    } exp_t;

    exp_t core_q[$];
    exp_t dbg_q[$];

    logic [7:0]  ref_mem [0:4095] = '{default: '0};
    logic [31:0] sram    [0:1023] = '{default: '0};

    dmem_arbiter #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_size(core_size), .core_unsigned(core_unsigned),
        .core_rdata(core_rdata), .core_stall(core_stall), .core_misalign(core_misalign),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory macro.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
        int nbytes;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        int          b;
        int          nbytes;
        logic [31:0] v;
        b      = int'(a[11:0]);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v      = '0;
        for (int i = nbytes - 1; i >= 0; i--) v = (v << 8) | 32'(ref_mem[b + i]);
        if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int b;
        int nbytes;
        b      = int'(a[11:0]);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) ref_mem[b + i] = d[8*i +: 8];
    endtask

    task automatic core_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input bit uns,
                           output int waits, output logic [3:0] be, output logic [31:0] wd,
                           output logic [9:0] ma, output logic en);
        exp_t e;
        bit   done;
        e.mis      = ref_misaligned(a, sz);
        e.chk_data = e.mis || !we;
        e.rdata    = '0;
        if (!e.mis) begin
            if (we) ref_store(a, d, sz);
            else    e.rdata = ref_load(a, sz, uns);
        end
        core_q.push_back(e);
        core_we = we; core_addr = a; core_wdata = d; core_size = sz; core_unsigned = uns;
        core_req = 1'b1;
        waits = 0; done = 0; be = '0; wd = '0; ma = '0; en = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (!core_stall) begin
                done = 1; be = mem_be; wd = mem_wdata; ma = mem_addr; en = mem_en;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL core_timeout: got no completion expected completion within 20 cycles");
        end
        @(posedge clk); #1;
        core_req = 1'b0;
    endtask

    task automatic dbg_op(input bit we, input logic [31:0] a, input logic [31:0] d, output int waits);
        exp_t        e;
        bit          done;
        logic [31:0] wa;
        wa         = {a[31:2], 2'b00};
        e.mis      = 1'b0;
        e.chk_data = !we;
        e.rdata    = '0;
        if (we) ref_store(wa, d, 2'd2);
        else    e.rdata = ref_load(wa, 2'd2, 1'b0);
        dbg_q.push_back(e);
        dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
        waits = 0; done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (dbg_ack) done = 1;
            else waits++;
        end
        if (!done) begin
            errors++;
            $display("FAIL dbg_timeout: got no ack expected ack within 20 cycles");
        end
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    // Monitor: pops predictions whenever a port completes.
    always @(negedge clk) begin
        if (reset) begin
            if (core_req && !core_stall) begin
                if (core_q.size() == 0) begin
                    errors++;
                    $display("FAIL core_unexpected: got completion expected none");
                end else begin
                    exp_t e;
                    e = core_q.pop_front();
                    check("core_misalign", 32'(core_misalign), 32'(e.mis));
                    if (e.chk_data) check("core_rdata", core_rdata, e.rdata);
                end
            end
            if (dbg_ack) begin
                if (dbg_q.size() == 0) begin
                    errors++;
                    $display("FAIL dbg_unexpected: got ack expected none");
                end else begin
                    exp_t e;
                    e = dbg_q.pop_front();
                    if (e.chk_data) check("dbg_rdata", dbg_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        int          cw, dw, acks;
        logic [3:0]  be;
        logic [31:0] wd, a, d;
        logic [9:0]  ma;
        logic        en;

        reset = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_size = '0; core_unsigned = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_outputs_zero",
              32'(|{core_rdata, core_stall, core_misalign, dbg_rdata, dbg_ack,
                    mem_en, mem_we, mem_addr, mem_be, mem_wdata}), 32'd0);
        @(posedge clk); #1;

        // First tie after reset goes to the core.
        fork
            core_op(1'b0, 32'd8, '0, 2'd2, 1'b0, cw, be, wd, ma, en);
            dbg_op(1'b0, 32'h104, '0, dw);
        join
        check("tie1_core_waits", 32'(cw), 32'd1);
        check("tie1_dbg_waits", 32'(dw), 32'd3);

        core_op(1'b1, 32'd8, 32'h2, 2'd2, 1'b0, cw, be, wd, ma, en);
        check("sw_waits", 32'(cw), 32'd0);
        check("sw_be", 32'(be), 32'hF);
        check("sw_addr", 32'(ma), 32'd2);
        core_op(1'b0, 32'd8, '0, 2'd2, 1'b0, cw, be, wd, ma, en);
        check("lw_waits", 32'(cw), 32'd1);

        core_op(1'b1, 32'd6, 32'h80, 2'd0, 1'b0, cw, be, wd, ma, en);
        check("sb_be", 32'(be), 32'h4);
        check("sb_wdata", wd, 32'h80808080);
        core_op(1'b0, 32'd6, '0, 2'd0, 1'b0, cw, be, wd, ma, en);
        core_op(1'b0, 32'd6, '0, 2'd0, 1'b1, cw, be, wd, ma, en);
        core_op(1'b1, 32'd14, 32'h1234_9abc, 2'd1, 1'b0, cw, be, wd, ma, en);
        check("sh_be", 32'(be), 32'hC);
        check("sh_wdata", wd, 32'h9abc9abc);
        core_op(1'b0, 32'd14, '0, 2'd1, 1'b0, cw, be, wd, ma, en);

        // Core won last, so the next tie goes to debug.
        fork
            core_op(1'b0, 32'd8, '0, 2'd2, 1'b0, cw, be, wd, ma, en);
            dbg_op(1'b0, 32'h104, '0, dw);
        join
        check("tie2_dbg_waits", 32'(dw), 32'd1);
        check("tie2_core_waits", 32'(cw), 32'd3);

        core_op(1'b0, 32'd3, '0, 2'd1, 1'b0, cw, be, wd, ma, en);
        check("mis_waits", 32'(cw), 32'd0);
        check("mis_mem_en", 32'(en), 32'd0);

        dbg_op(1'b1, 32'h200, 32'hcafe_f00d, dw);
        check("dbgw_waits", 32'(dw), 32'd0);

        // Abort a debug read with reset while it waits for data.
        dbg_we = 1'b0; dbg_addr = 32'h200; dbg_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (dbg_ack) acks++;
        end
        check("reset_abort_no_ack", 32'(acks), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        dbg_op(1'b0, 32'h200, '0, dw);
        check("reissue_waits", 32'(dw), 32'd1);

        for (int it = 0; it < 300; it++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) * 4);
            if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
            d = $urandom;
            if (kind == 0) begin
                core_op(1'($urandom_range(0, 1)), a, d, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), cw, be, wd, ma, en);
            end else begin
                logic [31:0] da;
                da = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(32, 63) * 4) |
                     32'($urandom_range(0, 3));
                if (kind == 1) begin
                    dbg_op(1'($urandom_range(0, 1)), da, $urandom, dw);
                end else begin
                    fork
                        core_op(1'($urandom_range(0, 1)), a, d, 2'($urandom_range(0, 3)),
                                1'($urandom_range(0, 1)), cw, be, wd, ma, en);
                        dbg_op(1'($urandom_range(0, 1)), da, $urandom, dw);
                    join
                end
            end
        end

        @(negedge clk);
        check("core_queue_drained", 32'(core_q.size()), 32'd0);
        check("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
